// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: fetch/decode/execute FSM with memory wait
// states, a bus-timeout watchdog and sticky illegal/bus-error status.
// Outputs are decoded combinationally from state, opcode, aluout and memReady.
module multicycle_control #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] aluout,
  input  logic              memReady,
  input  logic              resume,
  output logic              memReq,
  output logic              memWrite,
  output logic              pcSelect,
  output logic              pcEnable,
  output logic              adrSelect,
  output logic              ir1En,
  output logic              ir2En,
  output logic              regSelect,
  output logic              wd3Select,
  output logic              regWrite,
  output logic              op1Sel,
  output logic              op2Sel,
  output logic              aluOutEn,
  output logic [2:0]        aluControl,
  output logic              halted,
  output logic              illegal,
  output logic              busErr
);

  // A zero TIMEOUT disables the watchdog; keep a 1-bit counter so widths stay legal.
  localparam bit                TO_EN   = (TIMEOUT > 0);
  localparam int                CNT_W   = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [3:0] {
    S_FETCH1 = 4'd0,
    S_FETCH2 = 4'd1,
    S_DECODE = 4'd2,
    S_MEMLD  = 4'd3,
    S_MEMST  = 4'd4,
    S_ALU    = 4'd5,
    S_ALUWB  = 4'd6,
    S_BRANCH = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  state_t           state_r;
  state_t           next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             illegal_r;
  logic             bus_err_r;
  logic             set_illegal_s;
  logic             set_bus_err_s;
  logic             ready_s;
  logic             timeout_s;
  logic [2:0]       alu_fn_s;
  logic             taken_s;

  // While reset is held the outputs must look like FETCH1 with no ready.
  assign ready_s   = memReady & reset;
  // Only meaningful in states that drive memReq; those states test it after ready_s.
  assign timeout_s = TO_EN && (cnt_r == TO_LAST);

  // ALU function for register-register operations, from opcode[1:0].
  always_comb begin
    alu_fn_s = 3'b010;
    case (opcode[1:0])
      2'b00:   alu_fn_s = 3'b010;
      2'b01:   alu_fn_s = 3'b110;
      2'b10:   alu_fn_s = 3'b000;
      default: alu_fn_s = 3'b001;
    endcase
  end

  // Branch decision: unconditional, branch-if-zero, branch-if-negative.
  always_comb begin
    taken_s = 1'b0;
    case (opcode)
      4'b1000: taken_s = 1'b1;
      4'b1001: taken_s = (aluout == '0);
      4'b1010: taken_s = aluout[DATA_W-1];
      default: taken_s = 1'b0;
    endcase
  end

  // Next-state and control output decode.
  always_comb begin
    next_s        = state_r;
    set_illegal_s = 1'b0;
    set_bus_err_s = 1'b0;
    memReq        = 1'b0;
    memWrite      = 1'b0;
    pcSelect      = 1'b0;
    pcEnable      = 1'b0;
    adrSelect     = 1'b0;
    ir1En         = 1'b0;
    ir2En         = 1'b0;
    regSelect     = 1'b0;
    wd3Select     = 1'b0;
    regWrite      = 1'b0;
    op1Sel        = 1'b0;
    op2Sel        = 1'b0;
    aluOutEn      = 1'b0;
    aluControl    = 3'b010;
    halted        = 1'b0;
    case (state_r)
      S_FETCH1, S_FETCH2: begin
        memReq = 1'b1;
        op2Sel = 1'b1;
        if (ready_s) begin
          pcEnable = 1'b1;
          if (state_r == S_FETCH1) begin
            ir1En  = 1'b1;
            next_s = S_FETCH2;
          end else begin
            ir2En  = 1'b1;
            next_s = S_DECODE;
          end
        end else if (timeout_s) begin
          next_s        = S_HALT;
          set_bus_err_s = 1'b1;
        end else begin
          next_s = state_r;
        end
      end
      S_DECODE: begin
        case (opcode)
          4'b0000:                   next_s = S_MEMLD;
          4'b0001:                   next_s = S_MEMST;
          4'b0100, 4'b0101,
          4'b0110, 4'b0111:          next_s = S_ALU;
          4'b1000, 4'b1001, 4'b1010: next_s = S_BRANCH;
          4'b1011:                   next_s = S_HALT;
          default: begin
            next_s        = S_HALT;
            set_illegal_s = 1'b1;
          end
        endcase
      end
      S_MEMLD, S_MEMST: begin
        memReq    = 1'b1;
        memWrite  = (state_r == S_MEMST);
        adrSelect = 1'b1;
        op1Sel    = 1'b1;
        if (ready_s) begin
          regWrite = (state_r == S_MEMLD);
          next_s   = S_FETCH1;
        end else if (timeout_s) begin
          next_s        = S_HALT;
          set_bus_err_s = 1'b1;
        end else begin
          next_s = state_r;
        end
      end
      S_ALU: begin
        op1Sel     = 1'b1;
        aluOutEn   = 1'b1;
        aluControl = alu_fn_s;
        next_s     = S_ALUWB;
      end
      S_ALUWB: begin
        regSelect  = 1'b1;
        wd3Select  = 1'b1;
        regWrite   = 1'b1;
        aluControl = alu_fn_s;
        next_s     = S_FETCH1;
      end
      S_BRANCH: begin
        op1Sel     = 1'b1;
        aluControl = 3'b110;
        pcSelect   = taken_s;
        pcEnable   = taken_s;
        next_s     = S_FETCH1;
      end
      S_HALT: begin
        aluControl = 3'b000;
        halted     = 1'b1;
        if (resume && !illegal_r && !bus_err_r) begin
          next_s = S_FETCH1;
        end else begin
          next_s = S_HALT;
        end
      end
      default: begin
        next_s = S_FETCH1;
      end
    endcase
  end

  assign illegal = illegal_r;
  assign busErr  = bus_err_r;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_FETCH1;
    end else begin
      state_r <= next_s;
    end
  end

  // Memory wait counter: restarts on any state change or completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if ((next_s != state_r) || ready_s) begin
      cnt_r <= '0;
    end else if (memReq) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_r <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      illegal_r <= illegal_r | set_illegal_s;
      bus_err_r <= bus_err_r | set_bus_err_s;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control (DATA_W=8, TIMEOUT=4).
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [7:0] aluout = 8'd0;
  logic       memReady = 1'b1;
  logic       resume = 1'b0;
  logic memReq, memWrite, pcSelect, pcEnable, adrSelect, ir1En, ir2En;
  logic regSelect, wd3Select, regWrite, op1Sel, op2Sel, aluOutEn;
  logic [2:0] aluControl;
  logic halted, illegal, busErr;

  multicycle_control #(.DATA_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .aluout(aluout),
    .memReady(memReady), .resume(resume),
    .memReq(memReq), .memWrite(memWrite), .pcSelect(pcSelect),
    .pcEnable(pcEnable), .adrSelect(adrSelect), .ir1En(ir1En), .ir2En(ir2En),
    .regSelect(regSelect), .wd3Select(wd3Select), .regWrite(regWrite),
    .op1Sel(op1Sel), .op2Sel(op2Sel), .aluOutEn(aluOutEn),
    .aluControl(aluControl), .halted(halted), .illegal(illegal), .busErr(busErr)
  );

  always #5 clk = ~clk;

  // Output vector layout:
  // memReq memWrite pcSelect pcEnable _ adrSelect ir1En ir2En regSelect _
  // wd3Select regWrite op1Sel op2Sel _ aluOutEn _ aluControl _ halted illegal busErr
  logic [18:0] got;
  assign got = {memReq, memWrite, pcSelect, pcEnable, adrSelect, ir1En, ir2En,
                regSelect, wd3Select, regWrite, op1Sel, op2Sel, aluOutEn,
                aluControl, halted, illegal, busErr};

  localparam logic [18:0] E_F1W = 19'b1000_0000_0001_0_010_000;
  localparam logic [18:0] E_F1R = 19'b1001_0100_0001_0_010_000;
  localparam logic [18:0] E_F2W = 19'b1000_0000_0001_0_010_000;
  localparam logic [18:0] E_F2R = 19'b1001_0010_0001_0_010_000;
  localparam logic [18:0] E_DEC = 19'b0000_0000_0000_0_010_000;
  localparam logic [18:0] E_MLW = 19'b1000_1000_0010_0_010_000;
  localparam logic [18:0] E_MLR = 19'b1000_1000_0110_0_010_000;
  localparam logic [18:0] E_MS  = 19'b1100_1000_0010_0_010_000;
  localparam logic [18:0] E_BT  = 19'b0011_0000_0010_0_110_000;
  localparam logic [18:0] E_BN  = 19'b0000_0000_0010_0_110_000;
  localparam logic [18:0] E_HS  = 19'b0000_0000_0000_0_000_100;
  localparam logic [18:0] E_HI  = 19'b0000_0000_0000_0_000_110;
  localparam logic [18:0] E_HB  = 19'b0000_0000_0000_0_000_101;

  function automatic logic [18:0] e_alu(input logic [2:0] f);
    return {16'b0000_0000_0010_1, f} << 3;
  endfunction
  function automatic logic [18:0] e_awb(input logic [2:0] f);
    return {16'b0000_0001_1100_0, f} << 3;
  endfunction

  typedef struct packed {
    logic [3:0]  op;
    logic [7:0]  alu;
    logic        rdy;
    logic        res;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [18:0] e);
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s got=%b required=%b", nm, got, e);
    end
  endtask

  // Drive one cycle at the falling edge, check 1ns later, advance past the rising edge.
  task automatic apply_v(input logic [3:0] op, input logic [7:0] alu,
                         input logic rdy, input logic res,
                         input logic [18:0] e, input string nm);
    opcode   = op;
    aluout   = alu;
    memReady = rdy;
    resume   = res;
    #1;
    chk(nm, e);
    @(negedge clk);
  endtask

  task automatic add(input logic [3:0] op, input logic [7:0] alu,
                     input logic rdy, input logic res, input logic [18:0] e);
    tbl.push_back(vec_t'({op, alu, rdy, res, e}));
  endtask

  task automatic add_fetch(input logic [3:0] op);
    add(op, 8'h00, 1'b1, 1'b0, E_F1R);
    add(op, 8'h00, 1'b1, 1'b0, E_F2R);
    add(op, 8'h00, 1'b1, 1'b0, E_DEC);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    memReady = 1'b1;
    resume   = 1'b0;
    opcode   = 4'd0;
    aluout   = 8'd0;
    #1;
    chk("reset_outs", E_F1W);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // ALU ops, each back in FETCH1 on its sixth cycle
    add_fetch(4'b0101); add(4'b0101, 8'h00, 1'b1, 1'b0, e_alu(3'b110)); add(4'b0101, 8'h00, 1'b1, 1'b0, e_awb(3'b110));
    add_fetch(4'b0110); add(4'b0110, 8'h00, 1'b1, 1'b0, e_alu(3'b000)); add(4'b0110, 8'h00, 1'b1, 1'b0, e_awb(3'b000));
    add_fetch(4'b0100); add(4'b0100, 8'h00, 1'b1, 1'b0, e_alu(3'b010)); add(4'b0100, 8'h00, 1'b1, 1'b0, e_awb(3'b010));
    add_fetch(4'b0111); add(4'b0111, 8'h00, 1'b1, 1'b0, e_alu(3'b001)); add(4'b0111, 8'h00, 1'b1, 1'b0, e_awb(3'b001));
    // Load with three wait states
    add_fetch(4'b0000);
    for (int i = 0; i < 3; i++) add(4'b0000, 8'h00, 1'b0, 1'b0, E_MLW);
    add(4'b0000, 8'h00, 1'b1, 1'b0, E_MLR);
    // Store
    add_fetch(4'b0001); add(4'b0001, 8'h00, 1'b1, 1'b0, E_MS);
    // Branches
    add_fetch(4'b1001); add(4'b1001, 8'h00, 1'b1, 1'b0, E_BT);
    add_fetch(4'b1001); add(4'b1001, 8'h01, 1'b1, 1'b0, E_BN);
    add_fetch(4'b1010); add(4'b1010, 8'h80, 1'b1, 1'b0, E_BT);
    add_fetch(4'b1010); add(4'b1010, 8'h7f, 1'b1, 1'b0, E_BN);
    add_fetch(4'b1000); add(4'b1000, 8'h55, 1'b1, 1'b0, E_BT);
    // Fetch waits; ready arrives on the 4th FETCH1 cycle, so no bus error
    for (int i = 0; i < 3; i++) add(4'b1011, 8'h00, 1'b0, 1'b0, E_F1W);
    add(4'b1011, 8'h00, 1'b1, 1'b0, E_F1R);
    add(4'b1011, 8'h00, 1'b0, 1'b0, E_F2W);
    add(4'b1011, 8'h00, 1'b1, 1'b0, E_F2R);
    add(4'b1011, 8'h00, 1'b1, 1'b0, E_DEC);
    // Soft halt: ready ignored without a request, resume pulse returns to FETCH1
    add(4'b1011, 8'h00, 1'b1, 1'b0, E_HS);
    add(4'b1011, 8'h00, 1'b1, 1'b1, E_HS);
    add(4'b0000, 8'h00, 1'b1, 1'b0, E_F1R);
    add(4'b0000, 8'h00, 1'b1, 1'b0, E_F2R);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      apply_v(tbl[i].op, tbl[i].alu, tbl[i].rdy, tbl[i].res, tbl[i].exp,
              $sformatf("vec%0d", i));
    end

    // Bus timeout in FETCH1 after 4 unanswered cycles; resume has no effect
    do_reset();
    for (int i = 0; i < 4; i++) apply_v(4'b0000, 8'h00, 1'b0, 1'b0, E_F1W, "to_wait");
    apply_v(4'b0000, 8'h00, 1'b0, 1'b0, E_HB, "to_halt");
    apply_v(4'b0000, 8'h00, 1'b0, 1'b1, E_HB, "to_resume");
    apply_v(4'b0000, 8'h00, 1'b1, 1'b0, E_HB, "to_sticky");

    // Illegal opcode: sticky halt, then asynchronous reset clears it mid-cycle
    do_reset();
    apply_v(4'b1100, 8'h00, 1'b1, 1'b0, E_F1R, "il_f1");
    apply_v(4'b1100, 8'h00, 1'b1, 1'b0, E_F2R, "il_f2");
    apply_v(4'b1100, 8'h00, 1'b1, 1'b0, E_DEC, "il_dec");
    apply_v(4'b1100, 8'h00, 1'b1, 1'b0, E_HI,  "il_halt");
    apply_v(4'b1100, 8'h00, 1'b1, 1'b1, E_HI,  "il_resume");
    #2;
    reset = 1'b0;
    #1;
    chk("il_async_rst", E_F1W);
    @(negedge clk);
    reset = 1'b1;

    // Reset in the middle of a waiting store drops memWrite at once
    apply_v(4'b0001, 8'h00, 1'b1, 1'b0, E_F1R, "st_f1");
    apply_v(4'b0001, 8'h00, 1'b1, 1'b0, E_F2R, "st_f2");
    apply_v(4'b0001, 8'h00, 1'b1, 1'b0, E_DEC, "st_dec");
    apply_v(4'b0001, 8'h00, 1'b0, 1'b0, E_MS,  "st_wait");
    #2;
    reset = 1'b0;
    #1;
    chk("st_async_rst", E_F1W);
    @(negedge clk);
    reset = 1'b1;
    apply_v(4'b0001, 8'h00, 1'b1, 1'b0, E_F1R, "st_post_rst");
    apply_v(4'b0001, 8'h00, 1'b1, 1'b0, E_F2R, "st_post_f2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
